// File: rtl/keypad_scanner_if.sv
// Signal bundle between the keypad scanner and the keypad/encoder side.
// master: the scanner (drives columns and encoder inputs); slave: keypad and consumer.
interface keypad_scanner_if;
    logic [3:0] row_in;
    logic [3:0] column_n;
    logic [3:0] keyboard;
    logic [1:0] counter;
    logic       key_strobe;
    logic       key_down;

    modport master (
        input  row_in,
        output column_n,
        output keyboard,
        output counter,
        output key_strobe,
        output key_down
    );

    modport slave (
        output row_in,
        input  column_n,
        input  keyboard,
        input  counter,
        input  key_strobe,
        input  key_down
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with row synchroniser and press/release debounce.
// Feeds the hex encoder's keyboard/counter inputs and flags accepted key presses.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 16,
    parameter int unsigned DEBOUNCE_CNT = 1024
) (
    input logic              clock,
    input logic              reset_n,
    keypad_scanner_if.master bus
);

    localparam int unsigned TickW = $clog2(SCAN_DIV);
    localparam int unsigned DbW   = $clog2(DEBOUNCE_CNT);

    localparam logic [TickW-1:0] TickLast = TickW'(SCAN_DIV - 1);
    localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StPressed,
        StRelease
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [3:0]       row_cap_q, row_cap_d;
    logic [1:0]       counter_q, counter_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [DbW-1:0]   db_q, db_d;
    logic             key_strobe_q, key_strobe_d;
    logic             key_down_q, key_down_d;

    function automatic logic is_one_cold(input logic [3:0] rows);
        return (rows == 4'b1110) || (rows == 4'b1101) ||
               (rows == 4'b1011) || (rows == 4'b0111);
    endfunction

    always_comb begin
        state_d      = state_q;
        sync1_d      = bus.row_in;
        sync2_d      = sync1_q;
        row_cap_d    = row_cap_q;
        counter_d    = counter_q;
        tick_d       = tick_q;
        db_d         = db_q;
        key_strobe_d = 1'b0;
        key_down_d   = key_down_q;

        case (state_q)
            StScan: begin
                // Rows are only looked at on the tick terminal so the keypad and
                // synchroniser have settled after the last column change.
                if (tick_q == TickLast) begin
                    tick_d = '0;
                    if (is_one_cold(sync2_q)) begin
                        row_cap_d = sync2_q;
                        db_d      = '0;
                        state_d   = StDebounce;
                    end else begin
                        counter_d = counter_q + 2'd1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end

            StDebounce: begin
                if (sync2_q == row_cap_q) begin
                    if (db_q == DbLast) begin
                        state_d      = StPressed;
                        key_strobe_d = 1'b1;
                        key_down_d   = 1'b1;
                    end else begin
                        db_d = db_q + 1'b1;
                    end
                end else begin
                    state_d = StScan;
                    tick_d  = '0;
                end
            end

            StPressed: begin
                if (sync2_q == 4'b1111) begin
                    state_d = StRelease;
                    db_d    = '0;
                end
            end

            StRelease: begin
                if (sync2_q == 4'b1111) begin
                    if (db_q == DbLast) begin
                        state_d    = StScan;
                        key_down_d = 1'b0;
                        counter_d  = counter_q + 2'd1;
                        tick_d     = '0;
                    end else begin
                        db_d = db_q + 1'b1;
                    end
                end else begin
                    // Release bounce: back to held without a new strobe.
                    state_d = StPressed;
                end
            end

            default: state_d = StScan;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StScan;
            sync1_q      <= 4'b1111;
            sync2_q      <= 4'b1111;
            row_cap_q    <= 4'b1111;
            counter_q    <= 2'd0;
            tick_q       <= '0;
            db_q         <= '0;
            key_strobe_q <= 1'b0;
            key_down_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            row_cap_q    <= row_cap_d;
            counter_q    <= counter_d;
            tick_q       <= tick_d;
            db_q         <= db_d;
            key_strobe_q <= key_strobe_d;
            key_down_q   <= key_down_d;
        end
    end

    assign bus.column_n   = ~(4'b0001 << counter_q);
    assign bus.keyboard   = sync2_q;
    assign bus.counter    = counter_q;
    assign bus.key_strobe = key_strobe_q;
    assign bus.key_down   = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a column-aware keypad model and a
// registered hex encoder model downstream.
module tb_keypad_scanner;

    logic clock;
    logic reset_n;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (8)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (kif)
    );

    // Keypad model: the pressed key pulls its row pattern only while its column is driven.
    logic       press_en;
    logic [1:0] press_col;
    logic [3:0] press_rows;

    assign kif.row_in = (press_en && (kif.column_n[press_col] == 1'b0)) ? press_rows : 4'hF;

    // Encoder model: legend 1..F,0 row-major, registered one cycle after its inputs.
    function automatic logic [3:0] enc(input logic [1:0] col, input logic [3:0] rows);
        logic [3:0] base;
        case (rows)
            4'b1110: base = 4'd0;
            4'b1101: base = 4'd4;
            4'b1011: base = 4'd8;
            4'b0111: base = 4'd12;
            default: base = 4'd0;
        endcase
        return base + {2'b00, col} + 4'd1;
    endfunction

    logic [3:0] hex_q;
    always @(posedge clock) hex_q <= enc(kif.counter, kif.keyboard);

    int checks = 0;
    int errors = 0;
    int strobes = 0;

    always @(negedge clock) if (kif.key_strobe === 1'b1) strobes++;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_strobe(input int budget, output int waited);
        waited = -1;
        for (int n = 1; n <= budget; n++) begin
            step();
            if (kif.key_strobe === 1'b1) begin
                waited = n;
                break;
            end
        end
    endtask

    task automatic wait_release(input int budget, output int waited);
        waited = -1;
        for (int n = 1; n <= budget; n++) begin
            step();
            if (kif.key_down === 1'b0) begin
                waited = n;
                break;
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_counter"}, 32'(kif.counter), 0);
        chk({tag, "_column_n"}, 32'(kif.column_n), 32'hE);
        chk({tag, "_keyboard"}, 32'(kif.keyboard), 32'hF);
        chk({tag, "_strobe"}, 32'(kif.key_strobe), 0);
        chk({tag, "_down"}, 32'(kif.key_down), 0);
    endtask

    initial begin
        int waited;
        int first;
        int base_strobes;
        logic [3:0] col_seq [4];

        col_seq[0] = 4'b1101;
        col_seq[1] = 4'b1011;
        col_seq[2] = 4'b0111;
        col_seq[3] = 4'b1110;

        press_en   = 1'b0;
        press_col  = 2'd0;
        press_rows = 4'hF;
        reset_n    = 1'b0;
        repeat (2) step();
        chk_reset_vals("reset");

        // Idle scan: one column step every 4 cycles, no strobes.
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            repeat (4) step();
            chk($sformatf("idle_col%0d", i), 32'(kif.column_n), 32'(col_seq[i]));
        end
        chk("idle_no_strobe", 32'(strobes), 0);

        // Clean press at column 2, row 1.
        press_en   = 1'b1;
        press_col  = 2'd2;
        press_rows = 4'b1101;
        wait_strobe(100, waited);
        chk("press_latency", 32'(waited), 20);
        chk("press_counter", 32'(kif.counter), 2);
        chk("press_keyboard", 32'(kif.keyboard), 32'hD);
        chk("press_down", 32'(kif.key_down), 1);
        step();
        chk("press_hex", 32'(hex_q), 32'h7);
        chk("press_strobe_1cyc", 32'(kif.key_strobe), 0);
        repeat (9) step();
        chk("press_held_counter", 32'(kif.counter), 2);
        chk("press_one_strobe", 32'(strobes), 1);

        press_en = 1'b0;
        repeat (10) step();
        chk("release_still_down", 32'(kif.key_down), 1);
        step();
        chk("release_down_fall", 32'(kif.key_down), 0);
        chk("release_counter", 32'(kif.counter), 3);

        // Press bounce on column 0: toggle every 3 cycles for 20 cycles, then hold.
        repeat (4) step();
        chk("bounce_start_counter", 32'(kif.counter), 0);
        base_strobes = strobes;
        first        = -1;
        press_en     = 1'b1;
        press_col    = 2'd0;
        for (int k = 0; k < 40; k++) begin
            press_rows = (k < 20 && ((k / 3) % 2) == 1) ? 4'hF : 4'b1110;
            step();
            if (kif.key_strobe === 1'b1 && first < 0) first = k + 1;
        end
        chk("bounce_strobe_time", 32'(first), 30);
        chk("bounce_one_strobe", 32'(strobes - base_strobes), 1);
        chk("bounce_counter", 32'(kif.counter), 0);

        // Release bounce: 5 cycles released, 1 cycle of a low row, then released.
        base_strobes = strobes;
        first        = -1;
        for (int j = 0; j < 40; j++) begin
            press_rows = (j == 5) ? 4'b1011 : 4'hF;
            step();
            if (kif.key_down === 1'b0) begin
                first = j + 1;
                break;
            end
        end
        chk("relbounce_fall_time", 32'(first), 17);
        chk("relbounce_no_strobe", 32'(strobes - base_strobes), 0);
        chk("relbounce_counter", 32'(kif.counter), 1);

        // Multi-key: two rows low on column 0 never accepted; scan keeps going.
        base_strobes = strobes;
        press_rows   = 4'b1100;
        for (int i = 1; i <= 8; i++) begin
            repeat (4) step();
            chk($sformatf("multi_counter%0d", i), 32'(kif.counter), 32'((1 + i) % 4));
        end
        chk("multi_no_strobe", 32'(strobes - base_strobes), 0);

        press_col  = 2'd3;
        press_rows = 4'b0111;
        wait_strobe(100, waited);
        chk("col3_latency", 32'(waited), 20);
        chk("col3_counter", 32'(kif.counter), 3);
        step();
        chk("col3_hex", 32'(hex_q), 32'h0);

        press_en = 1'b0;
        wait_release(100, waited);
        chk("col3_release", 32'(waited), 11);
        chk("col3_next_counter", 32'(kif.counter), 0);

        // Reset asserted mid-debounce at db=5 on column 1.
        base_strobes = strobes;
        press_en     = 1'b1;
        press_col    = 2'd1;
        press_rows   = 4'b1011;
        repeat (13) step();
        chk("db5_counter", 32'(kif.counter), 1);
        reset_n  = 1'b0;
        press_en = 1'b0;
        #1;
        chk("async_reset_column", 32'(kif.column_n), 32'hE);
        step();
        chk_reset_vals("midreset");
        reset_n = 1'b1;
        repeat (4) step();
        chk("restart_counter", 32'(kif.counter), 1);
        repeat (12) step();
        chk("restart_no_strobe", 32'(strobes - base_strobes), 0);
        chk("restart_down", 32'(kif.key_down), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
